rgb_cmp_pwm: RTL and testbench

- Parametrised, clocked successor to the 2-bit combinational RGB comparator.
- Compares two WIDTH-bit unsigned operands and selects one colour: red for a>b, green for a==b, blue for a<b.
- Adds input registering, a stability filter (glitch rejection), a state machine, and a PWM brightness stage.
- Sits between the switch/operand logic and the board RGB LED pins.

---
 rtl/rgb_cmp_pwm_if.sv | 17 +
 rtl/rgb_cmp_pwm.sv | 62 ++++++
 tb/tb_rgb_cmp_pwm.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rgb_cmp_pwm_if.sv
// rgb_cmp_pwm_if: operand, brightness and enable inputs plus LED/status outputs of rgb_cmp_pwm
interface rgb_cmp_pwm_if #(
   parameter int WIDTH    = 4,
   parameter int PWM_BITS = 8
);
   logic [WIDTH-1:0]    a;
   logic [WIDTH-1:0]    b;
   logic [PWM_BITS-1:0] duty;
   logic                en;
   logic                red;
   logic                green;
   logic                blue;
   logic                valid;
   logic [1:0]          cmp_state;
   modport master (output a, b, duty, en, input red, green, blue, valid, cmp_state);
   modport slave  (input a, b, duty, en, output red, green, blue, valid, cmp_state);
endinterface

// File: rtl/rgb_cmp_pwm.sv
// rgb_cmp_pwm: filtered unsigned magnitude compare driving a PWM-dimmed one-hot RGB LED
module rgb_cmp_pwm #(
   parameter int WIDTH         = 4,
   parameter int PWM_BITS      = 8,
   parameter int STABLE_CYCLES = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   rgb_cmp_pwm_if.slave bus
);
   localparam int SW = $clog2(STABLE_CYCLES + 1);
   typedef enum logic [1:0] {IDLE = 2'b00, SETTLING = 2'b01, LOCKED = 2'b10} state_t;
   logic [WIDTH-1:0]    a_q, b_q;
   logic [PWM_BITS-1:0] pwm_cnt_q, duty_q;
   logic [SW-1:0]       stab_cnt_q, stab_cnt_d;
   logic [2:0]          raw, last_raw_q, committed_q, rgb_q;
   logic                changed, stable, pwm_on;
   state_t              state_q, state_d;
   assign raw        = {a_q > b_q, a_q == b_q, a_q < b_q};
   assign changed    = raw != last_raw_q;
   assign stable     = stab_cnt_q == SW'(STABLE_CYCLES);
   assign pwm_on     = pwm_cnt_q < duty_q;
   assign stab_cnt_d = changed ? SW'(1) : stable ? stab_cnt_q : stab_cnt_q + 1'b1;
   // a stable count that coincides with a new raw value keeps the FSM settling
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     state_d = SETTLING;
         SETTLING: state_d = (stable && !changed) ? LOCKED : SETTLING;
         LOCKED:   state_d = changed ? SETTLING : LOCKED;
         default:  state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q         <= '0;
         b_q         <= '0;
         pwm_cnt_q   <= '0;
         duty_q      <= '0;
         stab_cnt_q  <= '0;
         last_raw_q  <= '0;
         committed_q <= '0;
         rgb_q       <= '0;
         state_q     <= IDLE;
      end else begin
         a_q        <= bus.a;
         b_q        <= bus.b;
         pwm_cnt_q  <= pwm_cnt_q + 1'b1;
         duty_q     <= &pwm_cnt_q ? bus.duty : duty_q;
         last_raw_q <= raw;
         stab_cnt_q <= stab_cnt_d;
         if (stable) committed_q <= last_raw_q;
         rgb_q      <= committed_q & {3{pwm_on & bus.en}};
         state_q    <= state_d;
      end
   end
   assign bus.red       = rgb_q[2];
   assign bus.green     = rgb_q[1];
   assign bus.blue      = rgb_q[0];
   assign bus.valid     = state_q == LOCKED;
   assign bus.cmp_state = state_q;
endmodule

// File: tb/tb_rgb_cmp_pwm.sv
// tb_rgb_cmp_pwm: directed colour/glitch/PWM/enable/reset steps, then random operands against a history model
module tb_rgb_cmp_pwm;
   localparam int STB = 4;
   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_cmp = 0;
   int         n_bad = 0;
   int         k     = 0;
   int         gcnt;
   int         m_r1, m_r2;
   logic [2:0] m_c1, m_c2, m_comm;
   logic [3:0] m_cnt, m_dq;
   logic [2:0] rgb;
   rgb_cmp_pwm_if #(.WIDTH(4), .PWM_BITS(4)) bus ();
   rgb_cmp_pwm #(.WIDTH(4), .PWM_BITS(4), .STABLE_CYCLES(STB)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );
   assign rgb = {bus.red, bus.green, bus.blue};
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // model state: compare-result history (value and run length) one and two edges back
   task automatic model_init();
      m_c1   = 3'b010;
      m_r1   = 1;
      m_c2   = 3'b000;
      m_r2   = 0;
      m_comm = 3'b000;
      m_cnt  = 4'd0;
      m_dq   = 4'd0;
      k      = 0;
   endtask
   task automatic tick();
      logic [2:0] ca, e_rgb, e_comm;
      logic       e_valid;
      int         e_r;
      ca      = {bus.a > bus.b, bus.a == bus.b, bus.a < bus.b};
      e_rgb   = m_comm & {3{(m_cnt < m_dq) && bus.en}};
      e_valid = m_r1 >= STB + 1;
      e_comm  = (m_r2 >= STB) ? m_c2 : m_comm;
      e_r     = (ca == m_c1) ? m_r1 + 1 : 1;
      if (m_cnt == 4'hF) m_dq = bus.duty;
      m_cnt  = m_cnt + 4'd1;
      m_c2   = m_c1;
      m_r2   = m_r1;
      m_c1   = ca;
      m_r1   = e_r;
      m_comm = e_comm;
      @(posedge clk);
      #1;
      k++;
      chk($sformatf("m_rgb@%0d", k), 8'(rgb), 8'(e_rgb));
      chk($sformatf("m_valid@%0d", k), 8'(bus.valid), 8'(e_valid));
      chk($sformatf("m_state@%0d", k), 8'(bus.cmp_state), e_valid ? 8'd2 : 8'd1);
      chk($sformatf("onehot@%0d", k), 8'($countones(rgb) <= 1), 8'd1);
   endtask
   task automatic run_to(input int n);
      while (k < n) tick();
   endtask
   initial begin
      bus.a = 4'd10; bus.b = 4'd5; bus.duty = 4'd15; bus.en = 1'b1;
      #12;
      chk("rst_rgb", 8'(rgb), 8'd0);
      chk("rst_valid", 8'(bus.valid), 8'd0);
      chk("rst_state", 8'(bus.cmp_state), 8'd0);
      rst_n = 1'b1;
      model_init();
      tick();      chk("A_state1", 8'(bus.cmp_state), 8'd1);
      run_to(5);   chk("A_valid5", 8'(bus.valid), 8'd0);
      tick();      chk("A_valid6", 8'(bus.valid), 8'd1);
      run_to(16);  chk("A_dutyq0", 8'(rgb), 8'd0);
      tick();      chk("A_red17", 8'(rgb), 8'b100);
      run_to(32);  chk("A_offcnt32", 8'(rgb), 8'd0);
      tick();      chk("A_red33", 8'(rgb), 8'b100);
      bus.a = 4'd5; bus.b = 4'd5;
      run_to(39);  chk("B_old39", 8'(rgb), 8'b100);
      chk("B_state39", 8'(bus.cmp_state), 8'd2);
      tick();      chk("B_green40", 8'(rgb), 8'b010);
      bus.a = 4'd0; bus.b = 4'd15;
      tick();      chk("C_valid41", 8'(bus.valid), 8'd1);
      tick();      chk("C_state42", 8'(bus.cmp_state), 8'd1);
      run_to(46);  chk("C_state46", 8'(bus.cmp_state), 8'd2);
      chk("C_green46", 8'(rgb), 8'b010);
      tick();      chk("C_blue47", 8'(rgb), 8'b001);
      bus.a = 4'd9; bus.b = 4'd3;
      run_to(56);
      bus.a = 4'd2;
      repeat (10) begin
         tick();
         if (k == 58) bus.a = 4'd9;
         chk($sformatf("D_rgb@%0d", k), 8'(rgb), ((k - 1) % 16 == 15) ? 8'd0 : 8'b100);
         if (k == 57 || k == 64) chk($sformatf("D_lock@%0d", k), 8'(bus.cmp_state), 8'd2);
         if (k == 58 || k == 63) chk($sformatf("D_settle@%0d", k), 8'(bus.cmp_state), 8'd1);
      end
      bus.a = 4'd5; bus.b = 4'd5; bus.duty = 4'd4;
      run_to(80);
      gcnt = 0;
      repeat (16) begin tick(); gcnt += int'(bus.green); if (k == 88) bus.duty = 4'd12; end
      chk("E_duty4", 8'(gcnt), 8'd4);
      gcnt = 0;
      repeat (16) begin tick(); gcnt += int'(bus.green); if (k == 100) bus.duty = 4'd0; end
      chk("E_duty12", 8'(gcnt), 8'd12);
      gcnt = 0;
      repeat (16) begin tick(); gcnt += int'(bus.green); if (k == 120) bus.duty = 4'd15; end
      chk("E_duty0", 8'(gcnt), 8'd0);
      bus.a = 4'd0; bus.b = 4'd15;
      run_to(140); chk("F_blue140", 8'(rgb), 8'b001);
      bus.en = 1'b0;
      repeat (10) begin
         tick();
         chk($sformatf("F_off@%0d", k), 8'(rgb), 8'd0);
         chk($sformatf("F_valid@%0d", k), 8'(bus.valid), 8'd1);
      end
      bus.en = 1'b1;
      tick();      chk("F_resume151", 8'(rgb), 8'b001);
      #3 rst_n = 1'b0;
      #1;
      chk("R_rgb", 8'(rgb), 8'd0);
      chk("R_valid", 8'(bus.valid), 8'd0);
      chk("R_state", 8'(bus.cmp_state), 8'd0);
      bus.a = 4'($urandom_range(0, 15)); bus.b = 4'($urandom_range(0, 15));
      #2 rst_n = 1'b1;
      model_init();
      repeat (200) begin
         bus.a    = 4'($urandom_range(0, 15));
         bus.b    = 4'($urandom_range(0, 15));
         bus.duty = 4'($urandom_range(0, 15));
         bus.en   = $urandom_range(0, 7) != 0;
         repeat ($urandom_range(1, 12)) tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
